// File: rtl/instr_fetch_ctrl.sv
// Program-counter sequencer with a reset sequence, debug halt/single-step and an optional call stack.
// Optional feature macro: CALL_STACK_EN (4-entry return-address LIFO for call/ret).
module instr_fetch_ctrl (
    input  logic       clk,
    input  logic       reset,
    input  logic       jmp,
    input  logic       jmp_nz,
    input  logic [3:0] ir_nibble,
    input  logic       zero_flag,
    input  logic       call,
    input  logic       ret,
    input  logic       halt_req,
    input  logic       step_req,
    output logic [7:0] pm_addr,
    output logic [7:0] pc,
    output logic       sync_reset,
    output logic [1:0] run_state,
    output logic       step_ack,
    output logic       stack_err
);

    // state   | meaning
    // RST_SEQ | datapath held in sync reset for two cycles, pc parked at 00
    // RUN     | fetch one instruction per cycle
    // HALTED  | debug halt, pc frozen, pm_addr re-presents pc
    // STEP    | single fetch under debug, then back to HALTED
    typedef enum logic [1:0] {
        RST_SEQ = 2'd0,
        RUN     = 2'd1,
        HALTED  = 2'd2,
        STEP    = 2'd3
    } state_t;

    state_t     state;
    state_t     state_nx;
    logic       rst_cnt;
    logic       rst_cnt_nx;
    logic       sync_q;
    logic       fetch;
    logic       take_jmp;
    logic [7:0] pc_inc;
    logic [7:0] jmp_tgt;
    logic       do_push;
    logic       do_pop;
    logic [7:0] stack_top;

    assign pc_inc   = pc + 8'd1;
    assign jmp_tgt  = {pc[7:4], ir_nibble};
    assign fetch    = (state == RUN) || (state == STEP);
    assign take_jmp = jmp || (jmp_nz && !zero_flag);

`ifdef CALL_STACK_EN
    logic [7:0] stack_mem [4];
    logic [2:0] sp;
    logic [1:0] top_idx;
    logic       stk_fault;
    logic       err_q;

    assign top_idx   = sp[1:0] - 2'd1;
    assign stack_top = stack_mem[top_idx];
    assign stack_err = err_q;

    // A full push or empty pop degrades to a plain fall-through fetch.
    always_comb begin
        do_push   = 1'b0;
        do_pop    = 1'b0;
        stk_fault = 1'b0;
        if (fetch && !take_jmp) begin
            if (call) begin
                if (sp == 3'd4) stk_fault = 1'b1;
                else            do_push   = 1'b1;
            end else if (ret) begin
                if (sp == 3'd0) stk_fault = 1'b1;
                else            do_pop    = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sp    <= 3'd0;
            err_q <= 1'b0;
        end else begin
            if (do_push)     sp <= sp + 3'd1;
            else if (do_pop) sp <= sp - 3'd1;
            if (stk_fault)   err_q <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) stack_mem[sp[1:0]] <= pc_inc;
    end
`else
    logic unused_stack_ctl;
    assign unused_stack_ctl = call ^ ret;
    assign do_push   = 1'b0;
    assign do_pop    = 1'b0;
    assign stack_top = 8'h00;
    assign stack_err = 1'b0;
`endif

    always_comb begin
        pm_addr = pc_inc;
        case (state)
            RST_SEQ: pm_addr = 8'h00;
            HALTED:  pm_addr = pc;
            default: begin
                if (take_jmp || do_push) pm_addr = jmp_tgt;
                else if (do_pop)         pm_addr = stack_top;
                else                     pm_addr = pc_inc;
            end
        endcase
    end

    always_comb begin
        state_nx   = state;
        rst_cnt_nx = rst_cnt;
        case (state)
            RST_SEQ: begin
                if (rst_cnt == 1'b0) state_nx = RUN;
                else                 rst_cnt_nx = rst_cnt - 1'b1;
            end
            RUN: begin
                if (halt_req) state_nx = HALTED;
            end
            HALTED: begin
                if (!halt_req)     state_nx = RUN;
                else if (step_req) state_nx = STEP;
            end
            STEP:    state_nx = HALTED;
            default: state_nx = RST_SEQ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= RST_SEQ;
            rst_cnt <= 1'b1;
            sync_q  <= 1'b1;
            pc      <= 8'h00;
        end else begin
            state   <= state_nx;
            rst_cnt <= rst_cnt_nx;
            sync_q  <= (state_nx == RST_SEQ);
            if (fetch) pc <= pm_addr;
        end
    end

    assign sync_reset = reset || sync_q;
    assign run_state  = state;
    assign step_ack   = (state == STEP);

endmodule

// File: tb/tb_instr_fetch_ctrl.sv
// Scoreboard bench for instr_fetch_ctrl; a behavioural model predicts pm_addr and post-edge state.
// Stack scenarios adapt to whether CALL_STACK_EN is defined.
module tb_instr_fetch_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       jmp = 1'b0, jmp_nz = 1'b0, zero_flag = 1'b0, call = 1'b0, ret = 1'b0;
    logic       halt_req = 1'b0, step_req = 1'b0;
    logic [3:0] ir_nibble = 4'h0;
    logic [7:0] pm_addr, pc;
    logic       sync_reset, step_ack, stack_err;
    logic [1:0] run_state;

    instr_fetch_ctrl dut (
        .clk(clk), .reset(reset), .jmp(jmp), .jmp_nz(jmp_nz), .ir_nibble(ir_nibble),
        .zero_flag(zero_flag), .call(call), .ret(ret), .halt_req(halt_req), .step_req(step_req),
        .pm_addr(pm_addr), .pc(pc), .sync_reset(sync_reset), .run_state(run_state),
        .step_ack(step_ack), .stack_err(stack_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] pc;
        logic [1:0] st;
        logic       err;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    logic [1:0] m_state;
    logic       m_rcnt;
    logic [7:0] m_pc;
    logic [7:0] m_stk [4];
    int         m_sp;
    logic       m_err;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_state = 2'd0;
        m_rcnt  = 1'b1;
        m_pc    = 8'h00;
        m_sp    = 0;
        m_err   = 1'b0;
        sb.delete();
    endtask

    // One clock: drive, predict, check pm_addr, push expectation, clock, pop and compare.
    task automatic cyc(input logic j, input logic jnz, input logic [3:0] nib, input logic zf,
                       input logic c, input logic r, input logic h, input logic s);
        logic [7:0] pm;
        logic       push, pop;
        exp_t       e;
        jmp = j; jmp_nz = jnz; ir_nibble = nib; zero_flag = zf;
        call = c; ret = r; halt_req = h; step_req = s;
        #1;
        push = 1'b0;
        pop  = 1'b0;
        pm   = m_pc + 8'd1;
        if (m_state == 2'd0)      pm = 8'h00;
        else if (m_state == 2'd2) pm = m_pc;
        else if (j || (jnz && !zf)) pm = {m_pc[7:4], nib};
`ifdef CALL_STACK_EN
        else if (c) begin
            if (m_sp < 4) begin pm = {m_pc[7:4], nib}; push = 1'b1; end
            else m_err = 1'b1;
        end else if (r) begin
            if (m_sp > 0) begin pm = m_stk[m_sp-1]; pop = 1'b1; end
            else m_err = 1'b1;
        end
`endif
        chk("pm_addr", pm_addr, pm);
        if (push) begin m_stk[m_sp] = m_pc + 8'd1; m_sp++; end
        if (pop)  m_sp--;
        case (m_state)
            2'd0: if (m_rcnt == 1'b0) m_state = 2'd1; else m_rcnt = 1'b0;
            2'd1: begin m_pc = pm; if (h) m_state = 2'd2; end
            2'd2: if (!h) m_state = 2'd1; else if (s) m_state = 2'd3;
            default: begin m_pc = pm; m_state = 2'd2; end
        endcase
        e.pc = m_pc; e.st = m_state; e.err = m_err;
        sb.push_back(e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        chk("pc", pc, e.pc);
        chk("run_state", run_state, e.st);
        chk("stack_err", stack_err, e.err);
        chk("sync_reset", sync_reset, e.st == 2'd0);
        chk("step_ack", step_ack, e.st == 2'd3);
    endtask

    task automatic idle();
        cyc(0, 0, 4'h0, 0, 0, 0, 0, 0);
    endtask

    task automatic run_to(input logic [7:0] target);
        for (int i = 0; i < 300 && m_pc != target; i++) idle();
        chk("reach_pc", pc, target);
    endtask

    task automatic apply_reset();
        @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        model_reset();
        chk("rst_pc", pc, 8'h00);
        chk("rst_state", run_state, 2'd0);
        chk("rst_sync", sync_reset, 1'b1);
        chk("rst_ack", step_ack, 1'b0);
        chk("rst_err", stack_err, 1'b0);
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        model_reset();
        #2;
        apply_reset();

        // reset sequence: two sync_reset cycles then RUN, pc 00,01,02
        idle();
        chk("seq_sync1", sync_reset, 1'b1);
        idle();
        chk("seq_run", run_state, 2'd1);
        chk("seq_pc0", pc, 8'h00);
        idle();
        chk("seq_pc1", pc, 8'h01);
        idle();
        chk("seq_pc2", pc, 8'h02);

        run_to(8'h37);
        cyc(1, 0, 4'hA, 0, 0, 0, 0, 0);
        chk("jmp_3a", pc, 8'h3A);
        cyc(0, 1, 4'h5, 1, 0, 0, 0, 0);
        chk("jnz_fall", pc, 8'h3B);
        cyc(0, 1, 4'h5, 0, 0, 0, 0, 0);
        chk("jnz_take", pc, 8'h35);
        cyc(1, 1, 4'h9, 0, 1, 1, 0, 0);
        chk("prio_jmp", pc, 8'h39);
        cyc(0, 0, 4'h2, 0, 0, 0, 0, 1);
        chk("step_in_run", run_state, 2'd1);

        run_to(8'hFF);
        idle();
        chk("wrap_pc", pc, 8'h00);
        chk("wrap_err", stack_err, 1'b0);

        run_to(8'h10);
        cyc(0, 0, 4'h0, 0, 0, 0, 1, 0);
        chk("halt_pc", pc, 8'h11);
        chk("halt_state", run_state, 2'd2);
        for (int i = 0; i < 3; i++) cyc(1, 0, 4'h3, 0, 0, 0, 1, 0);
        chk("halt_hold", pc, 8'h11);
        cyc(0, 0, 4'h0, 0, 0, 0, 1, 1);
        chk("step_ack_hi", step_ack, 1'b1);
        cyc(0, 0, 4'h0, 0, 0, 0, 1, 1);
        chk("step_pc", pc, 8'h12);
        chk("step_ret", run_state, 2'd2);
        chk("step_ack_lo", step_ack, 1'b0);
        cyc(0, 0, 4'h0, 0, 0, 0, 0, 1);
        chk("run_wins", run_state, 2'd1);

        run_to(8'h20);
        cyc(0, 0, 4'h4, 0, 1, 0, 0, 0);
        cyc(0, 0, 4'h8, 0, 1, 0, 0, 0);
        cyc(0, 0, 4'hC, 0, 1, 0, 0, 0);
        cyc(0, 0, 4'h0, 0, 1, 0, 0, 0);
        cyc(0, 0, 4'h4, 0, 1, 0, 0, 0);
`ifdef CALL_STACK_EN
        chk("ovf_pc", pc, 8'h21);
        chk("ovf_err", stack_err, 1'b1);
        cyc(0, 0, 4'h0, 0, 0, 1, 0, 0);
        chk("ret1", pc, 8'h2D);
        cyc(0, 0, 4'h0, 0, 0, 1, 0, 0);
        chk("ret2", pc, 8'h29);
        cyc(0, 0, 4'h0, 0, 0, 1, 0, 0);
        chk("ret3", pc, 8'h25);
        cyc(0, 0, 4'h0, 0, 0, 1, 0, 0);
        chk("ret4", pc, 8'h21);
        cyc(0, 0, 4'h0, 0, 0, 1, 0, 0);
        chk("ret_empty", pc, 8'h22);
`else
        chk("nocall_pc", pc, 8'h25);
        chk("nocall_err", stack_err, 1'b0);
        for (int i = 0; i < 5; i++) cyc(0, 0, 4'h0, 0, 0, 1, 0, 0);
        chk("noret_pc", pc, 8'h2A);
`endif

        // reset in the middle of a STEP
        cyc(0, 0, 4'h0, 0, 0, 0, 1, 0);
        cyc(0, 0, 4'h0, 0, 0, 0, 1, 1);
        chk("pre_rst_step", run_state, 2'd3);
        chk("pre_rst_ack", step_ack, 1'b1);
        reset = 1'b1;
        #1;
        chk("async_pc", pc, 8'h00);
        chk("async_ack", step_ack, 1'b0);
        chk("async_state", run_state, 2'd0);
        chk("async_sync", sync_reset, 1'b1);
        chk("async_err", stack_err, 1'b0);
        model_reset();
        @(posedge clk);
        #1;
        reset = 1'b0;
        idle();
        idle();
        idle();
        chk("post_rst_pc", pc, 8'h01);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
